// File: rtl/rf_writeback_arbiter_if.sv
// Write-back arbiter bus: ALU/LSU result handshakes in, register-file write port and busy out.
interface rf_writeback_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_data;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              busy;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, wb_we, wb_addr, wb_data, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, wb_we, wb_addr, wb_data, busy
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Register-file write-back arbiter: per-channel result FIFOs (ALU=0, LSU=1),
// round-robin grant of one head per cycle into a registered single write port.
module rf_writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  flush,
  rf_writeback_arbiter_if.slave wb_if
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RR_ALU, RR_LSU} rr_e;
  rr_e rr_q, rr_d;

  logic              in_valid [2];
  logic [ADDR_W-1:0] in_rd    [2];
  logic [DATA_W-1:0] in_data  [2];
  logic [ADDR_W-1:0] head_rd  [2];
  logic [DATA_W-1:0] head_data[2];

  logic [1:0] not_empty, ready, push, grant;
  logic       sel;

  logic              wb_we_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;

  assign in_valid[0] = wb_if.alu_valid;
  assign in_rd[0]    = wb_if.alu_rd;
  assign in_data[0]  = wb_if.alu_data;
  assign in_valid[1] = wb_if.lsu_valid;
  assign in_rd[1]    = wb_if.lsu_rd;
  assign in_data[1]  = wb_if.lsu_data;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [ADDR_W-1:0] rd_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem[DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;

    // Ready uses start-of-cycle occupancy, so a full FIFO never takes a push
    // even when it pops in the same cycle. Writes to x0 are handshaked then dropped.
    assign full         = (count == CNT_W'(DEPTH));
    assign not_empty[g] = (count != '0);
    assign ready[g]     = !full && !reset && !flush;
    assign push[g]      = in_valid[g] && ready[g] && (in_rd[g] != '0);
    assign head_rd[g]   = rd_mem[rd_ptr];
    assign head_data[g] = data_mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (reset || flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[g])  wr_ptr <= wr_ptr + 1'b1;
        if (grant[g]) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push[g]) - CNT_W'(grant[g]);
      end
    end

    always_ff @(posedge clk) begin
      if (push[g]) begin
        rd_mem[wr_ptr]   <= in_rd[g];
        data_mem[wr_ptr] <= in_data[g];
      end
    end
  end

  // Pointer only advances under contention; a lone channel is granted without touching it.
  always_comb begin
    grant = not_empty;
    rr_d  = rr_q;
    if (not_empty == 2'b11) begin
      grant = (rr_q == RR_ALU) ? 2'b01 : 2'b10;
      rr_d  = (rr_q == RR_ALU) ? RR_LSU : RR_ALU;
    end
    if (flush) rr_d = RR_ALU;
  end

  assign sel = grant[1];

  always_ff @(posedge clk) begin
    if (reset) rr_q <= RR_ALU;
    else       rr_q <= rr_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else if (flush) begin
      wb_we_q <= 1'b0;
    end else begin
      wb_we_q <= |grant;
      if (|grant) begin
        wb_addr_q <= head_rd[sel];
        wb_data_q <= head_data[sel];
      end
    end
  end

  assign wb_if.alu_ready = ready[0];
  assign wb_if.lsu_ready = ready[1];
  assign wb_if.wb_we     = wb_we_q;
  assign wb_if.wb_addr   = wb_addr_q;
  assign wb_if.wb_data   = wb_data_q;
  assign wb_if.busy      = (|not_empty) || wb_we_q;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: latency, round-robin, backpressure,
// x0 filter, flush and mid-burst reset.
module tb_rf_writeback_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  rf_writeback_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  rf_writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .wb_if (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    idle();
    bus.alu_rd = '0; bus.alu_data = '0; bus.lsu_rd = '0; bus.lsu_data = '0;
    tick(); tick();
    total++; if (bus.alu_ready !== 1'b0) $display("FAIL rst_alu_ready: got %b want 0", bus.alu_ready); else passed++;
    total++; if (bus.lsu_ready !== 1'b0) $display("FAIL rst_lsu_ready: got %b want 0", bus.lsu_ready); else passed++;
    total++; if (bus.wb_we !== 1'b0) $display("FAIL rst_we: got %b want 0", bus.wb_we); else passed++;
    total++; if (bus.wb_addr !== 5'd0) $display("FAIL rst_addr: got %0d want 0", bus.wb_addr); else passed++;
    total++; if (bus.wb_data !== 32'd0) $display("FAIL rst_data: got %h want 0", bus.wb_data); else passed++;
    reset = 1'b0;
    tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else passed++;
    total++; if (bus.alu_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", bus.alu_ready); else passed++;
  endtask

  task automatic test_latency();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1;
    total++; if (bus.alu_ready !== 1'b1) $display("FAIL lat_ready: got %b want 1", bus.alu_ready); else passed++;
    tick();
    idle();
    total++; if (bus.wb_we !== 1'b0) $display("FAIL lat_t1_we: got %b want 0", bus.wb_we); else passed++;
    tick();
    total++; if (bus.wb_we !== 1'b1) $display("FAIL lat_t2_we: got %b want 1", bus.wb_we); else passed++;
    total++; if (bus.wb_addr !== 5'd5) $display("FAIL lat_t2_addr: got %0d want 5", bus.wb_addr); else passed++;
    total++; if (bus.wb_data !== 32'hDEADBEEF) $display("FAIL lat_t2_data: got %h want deadbeef", bus.wb_data); else passed++;
    tick();
    total++; if (bus.wb_we !== 1'b0) $display("FAIL lat_t3_we: got %b want 0", bus.wb_we); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL lat_t3_busy: got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_rr_interleave();
    logic [4:0]  exp_a[8] = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
    logic [31:0] exp_d[8] = '{32'h10, 32'h20, 32'h11, 32'h21, 32'h12, 32'h22, 32'h13, 32'h23};
    logic [4:0]  got_a[$];
    logic [31:0] got_d[$];
    int ia = 0, ib = 0;
    logic acc_a, acc_b;
    for (int cyc = 0; cyc < 40 && !(got_a.size() == 8 && ia == 4 && ib == 4); cyc++) begin
      bus.alu_valid = (ia < 4); bus.alu_rd = 5'(1 + ia);  bus.alu_data = 32'(32'h10 + ia);
      bus.lsu_valid = (ib < 4); bus.lsu_rd = 5'(11 + ib); bus.lsu_data = 32'(32'h20 + ib);
      #1;
      acc_a = bus.alu_valid && bus.alu_ready;
      acc_b = bus.lsu_valid && bus.lsu_ready;
      tick();
      if (acc_a) ia++;
      if (acc_b) ib++;
      if (bus.wb_we) begin
        got_a.push_back(bus.wb_addr);
        got_d.push_back(bus.wb_data);
      end
    end
    idle();
    total++; if (got_a.size() != 8) $display("FAIL rr_count: got %0d want 8", got_a.size()); else passed++;
    for (int i = 0; i < 8 && i < got_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i])
        $display("FAIL rr_seq[%0d]: got rd=%0d data=%h want rd=%0d data=%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
      else passed++;
    end
    tick(); tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL rr_busy_end: got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_backpressure();
    int acc_a = 0, acc_b = 0, low_a = -1, low_b = -1;
    logic [31:0] wr_a[$];
    logic [31:0] wr_b[$];
    logic ha, hb, order_ok;
    for (int cyc = 0; cyc < 32; cyc++) begin
      bus.alu_valid = (cyc < 12); bus.alu_rd = 5'd3; bus.alu_data = 32'(32'h100 + acc_a);
      bus.lsu_valid = (cyc < 12); bus.lsu_rd = 5'd9; bus.lsu_data = 32'(32'h200 + acc_b);
      #1;
      if (!bus.alu_ready && low_a < 0) low_a = cyc;
      if (!bus.lsu_ready && low_b < 0) low_b = cyc;
      ha = bus.alu_valid && bus.alu_ready;
      hb = bus.lsu_valid && bus.lsu_ready;
      tick();
      if (ha) acc_a++;
      if (hb) acc_b++;
      if (bus.wb_we && bus.wb_addr == 5'd3) wr_a.push_back(bus.wb_data);
      if (bus.wb_we && bus.wb_addr == 5'd9) wr_b.push_back(bus.wb_data);
    end
    idle();
    total++; if (low_a < 0 || low_a > 3) $display("FAIL bp_alu_ready_drop: got cycle %0d want 0..3", low_a); else passed++;
    total++; if (low_b < 0 || low_b > 3) $display("FAIL bp_lsu_ready_drop: got cycle %0d want 0..3", low_b); else passed++;
    total++; if (wr_a.size() != acc_a) $display("FAIL bp_alu_count: written %0d accepted %0d", wr_a.size(), acc_a); else passed++;
    total++; if (wr_b.size() != acc_b) $display("FAIL bp_lsu_count: written %0d accepted %0d", wr_b.size(), acc_b); else passed++;
    order_ok = 1'b1;
    foreach (wr_a[k]) if (wr_a[k] !== 32'(32'h100 + k)) order_ok = 1'b0;
    total++; if (order_ok !== 1'b1) $display("FAIL bp_alu_order: got in-order=%b want 1", order_ok); else passed++;
    order_ok = 1'b1;
    foreach (wr_b[k]) if (wr_b[k] !== 32'(32'h200 + k)) order_ok = 1'b0;
    total++; if (order_ok !== 1'b1) $display("FAIL bp_lsu_order: got in-order=%b want 1", order_ok); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL bp_busy_end: got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_x0();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
    #1;
    total++; if (bus.alu_ready !== 1'b1) $display("FAIL x0_ready: got %b want 1", bus.alu_ready); else passed++;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.wb_we !== 1'b0) $display("FAIL x0_we[%0d]: got %b want 0", i, bus.wb_we); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL x0_busy[%0d]: got %b want 0", i, bus.busy); else passed++;
      tick();
    end
  endtask

  task automatic test_flush();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1;  bus.alu_data = 32'h31;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd11; bus.lsu_data = 32'h41;
    tick();
    bus.alu_rd = 5'd2;  bus.alu_data = 32'h32;
    bus.lsu_rd = 5'd12; bus.lsu_data = 32'h42;
    tick();
    flush = 1'b1;
    bus.alu_rd = 5'd3; bus.alu_data = 32'h33;
    #1;
    total++; if (bus.alu_ready !== 1'b0) $display("FAIL fl_alu_ready: got %b want 0", bus.alu_ready); else passed++;
    total++; if (bus.lsu_ready !== 1'b0) $display("FAIL fl_lsu_ready: got %b want 0", bus.lsu_ready); else passed++;
    total++; if (bus.wb_we !== 1'b1) $display("FAIL fl_inflight_we: got %b want 1", bus.wb_we); else passed++;
    tick();
    flush = 1'b0;
    bus.lsu_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
    #1;
    total++; if (bus.wb_we !== 1'b0) $display("FAIL fl_after_we: got %b want 0", bus.wb_we); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL fl_after_busy: got %b want 0", bus.busy); else passed++;
    total++; if (bus.alu_ready !== 1'b1) $display("FAIL fl_after_ready: got %b want 1", bus.alu_ready); else passed++;
    tick();
    idle();
    total++; if (bus.wb_we !== 1'b0) $display("FAIL fl_t1_we: got %b want 0", bus.wb_we); else passed++;
    tick();
    total++; if (bus.wb_we !== 1'b1) $display("FAIL fl_t2_we: got %b want 1", bus.wb_we); else passed++;
    total++; if (bus.wb_addr !== 5'd7) $display("FAIL fl_t2_addr: got %0d want 7", bus.wb_addr); else passed++;
    total++; if (bus.wb_data !== 32'h77) $display("FAIL fl_t2_data: got %h want 77", bus.wb_data); else passed++;
    tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL fl_end_busy: got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_reset_mid();
    // Two contended cycles leave the round-robin pointer at LSU before reset.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1;  bus.alu_data = 32'h10;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd11; bus.lsu_data = 32'h20;
    tick();
    bus.alu_rd = 5'd2;  bus.alu_data = 32'h11;
    bus.lsu_rd = 5'd12; bus.lsu_data = 32'h21;
    tick();
    reset = 1'b1;
    #1;
    total++; if (bus.alu_ready !== 1'b0) $display("FAIL rm_alu_ready: got %b want 0", bus.alu_ready); else passed++;
    total++; if (bus.lsu_ready !== 1'b0) $display("FAIL rm_lsu_ready: got %b want 0", bus.lsu_ready); else passed++;
    tick();
    total++; if (bus.wb_we !== 1'b0) $display("FAIL rm_we: got %b want 0", bus.wb_we); else passed++;
    total++; if (bus.wb_addr !== 5'd0) $display("FAIL rm_addr: got %0d want 0", bus.wb_addr); else passed++;
    total++; if (bus.wb_data !== 32'd0) $display("FAIL rm_data: got %h want 0", bus.wb_data); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", bus.busy); else passed++;
    reset = 1'b0;
    bus.alu_rd = 5'd2;  bus.alu_data = 32'hA;
    bus.lsu_rd = 5'd12; bus.lsu_data = 32'hB;
    #1;
    total++; if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b1)
      $display("FAIL rm_release_ready: got alu=%b lsu=%b want 1/1", bus.alu_ready, bus.lsu_ready); else passed++;
    tick();
    idle();
    total++; if (bus.wb_we !== 1'b0) $display("FAIL rm_t1_we: got %b want 0", bus.wb_we); else passed++;
    tick();
    total++; if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'd2 || bus.wb_data !== 32'hA)
      $display("FAIL rm_first_alu: got we=%b rd=%0d data=%h want 1/2/a", bus.wb_we, bus.wb_addr, bus.wb_data); else passed++;
    tick();
    total++; if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'd12 || bus.wb_data !== 32'hB)
      $display("FAIL rm_second_lsu: got we=%b rd=%0d data=%h want 1/12/b", bus.wb_we, bus.wb_addr, bus.wb_data); else passed++;
    tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL rm_end_busy: got %b want 0", bus.busy); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    test_reset();
    test_latency();
    test_rr_interleave();
    test_backpressure();
    test_x0();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
